// File: rtl/fifo_ctrl.sv
// FIFO pointer/count controller for an external dual-port RAM with
// first-word fall-through reads, occupancy flags and sticky error flags.
module fifo_ctrl #(
  parameter int unsigned addr_width = 3,
  parameter int unsigned af_level   = 6,
  parameter int unsigned ae_level   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  we,
  output logic [addr_width-1:0] w_addr,
  output logic [addr_width-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [addr_width:0] depth = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] af_th = (addr_width + 1)'(af_level);
  localparam logic [addr_width:0] ae_th = (addr_width + 1)'(ae_level);

  logic [addr_width-1:0] wptr;
  logic [addr_width-1:0] rptr;
  logic [addr_width:0]   cnt;
  logic                  wacc;
  logic                  racc;

  always_comb begin
    full         = (cnt == depth);
    empty        = (cnt == '0);
    almost_full  = (cnt >= af_th);
    almost_empty = (cnt <= ae_th);
    wacc         = wr & ~full;
    racc         = rd & ~empty;
    we           = wacc & ~reset;
    w_addr       = wptr;
    r_addr       = rptr;
    count        = cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wacc) wptr <= wptr + addr_width'(1);
      if (racc) rptr <= rptr + addr_width'(1);
      // Simultaneous accepted push and pop leave occupancy unchanged.
      case ({wacc, racc})
        2'b10:   cnt <= cnt + (addr_width + 1)'(1);
        2'b01:   cnt <= cnt - (addr_width + 1)'(1);
        default: cnt <= cnt;
      endcase
      if (wr & full)  overflow  <= 1'b1;
      if (rd & empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural RAM and
// a data scoreboard for the fall-through read path.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic       we;
  logic [2:0] w_addr;
  logic [2:0] r_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] mem [8];
  logic [7:0] w_data;
  logic [7:0] r_data;

  int   total = 0;
  int   bad   = 0;
  int   mcount;
  int   mw;
  int   mr;
  bit   mov;
  bit   mun;
  logic [7:0] q[$];

  fifo_ctrl #(.addr_width(3), .af_level(6), .ae_level(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .we(we),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (we) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];

  task automatic chk(input string ctx, input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", ctx, tag, obs, exp);
    end
  endtask

  task automatic outs(input string ctx);
    chk(ctx, "count", count, mcount);
    chk(ctx, "full", full, mcount == 8);
    chk(ctx, "empty", empty, mcount == 0);
    chk(ctx, "almost_full", almost_full, mcount >= 6);
    chk(ctx, "almost_empty", almost_empty, mcount <= 1);
    chk(ctx, "w_addr", w_addr, mw);
    chk(ctx, "r_addr", r_addr, mr);
    chk(ctx, "overflow", overflow, mov);
    chk(ctx, "underflow", underflow, mun);
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d,
                      input string ctx);
    bit wacc;
    bit racc;
    @(negedge clk);
    reset = 1'b0; wr = w; rd = r; w_data = d;
    wacc = w && (mcount != 8);
    racc = r && (mcount != 0);
    #1;
    chk(ctx, "we", we, wacc);
    if (racc) chk(ctx, "r_data", r_data, q[0]);
    @(posedge clk); #1;
    if (w && mcount == 8) mov = 1'b1;
    if (r && mcount == 0) mun = 1'b1;
    if (wacc) begin q.push_back(d); mw = (mw + 1) % 8; end
    if (racc) begin void'(q.pop_front()); mr = (mr + 1) % 8; end
    mcount = mcount + int'(wacc) - int'(racc);
    outs(ctx);
  endtask

  task automatic do_reset(input bit w, input bit r, input string ctx);
    @(negedge clk);
    reset = 1'b1; wr = w; rd = r; w_data = 8'hEE;
    #1;
    chk(ctx, "we_in_reset", we, 0);
    @(posedge clk); #1;
    mcount = 0; mw = 0; mr = 0; mov = 1'b0; mun = 1'b0;
    q.delete();
    outs(ctx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;
    do_reset(1'b0, 1'b0, "reset");

    // Underflow from empty, then recovery with a single write.
    step(1'b0, 1'b1, 8'h00, "rd_empty");
    step(1'b0, 1'b1, 8'h00, "rd_empty2");
    step(1'b1, 1'b0, 8'h5A, "wr_after_uf");
    do_reset(1'b0, 1'b0, "reset2");

    // Fill, overflow attempt, drain in order.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i * 8'h11), "fill");
    step(1'b1, 1'b0, 8'h99, "wr_full");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "drain");

    // Simultaneous traffic at count=4 wraps both pointers.
    do_reset(1'b0, 1'b0, "reset3");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), "pre4");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'hC0 + i), "rw4");
      chk("rw4", "lag", (int'(w_addr) - int'(r_addr) + 8) % 8, 4);
    end

    // wr=rd=1 at full and at empty boundaries.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hD0 + i), "to_full");
    step(1'b1, 1'b1, 8'hF0, "rw_full");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, "to_empty");
    step(1'b1, 1'b1, 8'hF1, "rw_empty");
    step(1'b0, 1'b1, 8'h00, "pop_last");

    // Reset mid-operation with a pending write.
    do_reset(1'b0, 1'b0, "reset4");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i), "pre5");
    do_reset(1'b1, 1'b0, "reset_mid");
    step(1'b1, 1'b0, 8'h77, "wr_post_reset");
    step(1'b0, 1'b1, 8'h00, "rd_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
